ttl_gate_bist: RTL and testbench

Parametrised built-in self-test engine for multi-channel 2-input TTL gate packages (74LS00/02/08/32/86-class parts). It drives exhaustive A/B stimulus into a gate package model, waits a programmable settle time, and checks each output against the selected logic function. It records the first failure and counts all failing vectors. It sits alongside the gate component models and replaces per-part hand-written stimulus with one clocked, reusable checker.

---
 rtl/ttl_gate_bist.sv | 118 +++++++++++
 tb/tb_ttl_gate_bist.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ttl_gate_bist.sv
// ttl_gate_bist: exhaustive-stimulus self-test engine for multi-channel 2-input gate packages
module ttl_gate_bist #(
  parameter int CHANNELS      = 4,
  parameter int SETTLE_CYCLES = 3,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            mode,
  output logic [CHANNELS-1:0]   a,
  output logic [CHANNELS-1:0]   b,
  input  logic [CHANNELS-1:0]   y,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2*CHANNELS-1:0] fail_vector,
  output logic [CHANNELS-1:0]   fail_mask,
  output logic [15:0]           err_count
);
  localparam int W  = 2 * CHANNELS;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("CHANNELS must be in 1..8");
  end
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, FIN} state_t;
  state_t state, state_n;
  logic [W-1:0] v;
  logic [CW-1:0] cnt;
  logic [2:0] mode_r;
  logic [CHANNELS-1:0] va, vb, e, miss;
  logic [15:0] err_n;
  logic accept, legal, fail, stop;
  // expected outputs come from the registered A/B, which hold V through CHECK
  always_comb begin
    va = '0;
    vb = '0;
    e = '0;
    miss = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      va[i] = v[2*i];
      vb[i] = v[2*i+1];
      e[i] = (mode_r[2] ? a[i] ^ b[i] : mode_r[1] ? a[i] | b[i] : a[i] & b[i]) ^ mode_r[0];
      miss[i] = y[i] !== e[i];
    end
  end
  assign accept = start && (state == IDLE || state == FIN);
  assign legal  = mode_r <= 3'd5;
  assign fail   = |miss;
  assign stop   = (fail && STOP_ON_FAIL) || (&v);
  assign err_n  = err_count + 16'(fail && err_count != 16'hFFFF);
  always_comb begin
    state_n = state;
    case (state)
      IDLE, FIN: state_n = accept ? DRIVE : state;
      DRIVE:     state_n = legal ? SETTLE : FIN;
      SETTLE:    state_n = cnt == CW'(1) ? CHECK : SETTLE;
      CHECK:     state_n = stop ? FIN : DRIVE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      v <= '0;
      cnt <= '0;
      mode_r <= '0;
      a <= '0;
      b <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail_vector <= '0;
      fail_mask <= '0;
      err_count <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        v <= '0;
        mode_r <= mode;
        busy <= 1'b1;
        done <= 1'b0;
        pass <= 1'b0;
        fail_vector <= '0;
        fail_mask <= '0;
        err_count <= '0;
      end
      if (state == DRIVE && legal) begin
        a <= va;
        b <= vb;
        cnt <= CW'(SETTLE_CYCLES);
      end
      if (state == DRIVE && !legal) begin
        busy <= 1'b0;
        done <= 1'b1;
        fail_mask <= '1;
      end
      if (state == SETTLE) cnt <= cnt - CW'(1);
      if (state == CHECK) begin
        err_count <= err_n;
        if (fail && err_count == 16'd0) begin
          fail_vector <= v;
          fail_mask <= miss;
        end
        if (stop) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= err_n == 16'd0;
          a <= '0;
          b <= '0;
        end else v <= v + W'(1);
      end
    end
  end
endmodule

// File: tb/tb_ttl_gate_bist.sv
// tb_ttl_gate_bist: randomized scoreboard bench; instance 0 runs to completion, instance 1 stops on first fail
module tb_ttl_gate_bist;
  localparam int CH = 4, S = 3, NV = 1 << (2*CH);
  typedef struct {int inst; int lat; bit pass; logic [2*CH-1:0] fv; logic [CH-1:0] fm; int err;} exp_t;
  logic clk = 0, rst;
  always #5 clk = ~clk;
  logic start[2];
  logic [2:0] mode;
  logic [CH-1:0] a[2], b[2], y[2], fm[2];
  logic busy[2], done[2], pass[2];
  logic [2*CH-1:0] fv[2];
  logic [15:0] err[2];
  logic [3:0] tt[6] = '{4'b1000, 4'b0111, 4'b1110, 4'b0001, 4'b0110, 4'b1001};
  int gm = 0, fch = 0, cyc = 0, acc_cyc = 0, nvec = 0, nbad = 0;
  bit fault_en = 0, fval = 0;
  exp_t q[$];
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar k = 0; k < 2; k++) begin : g_dut
    ttl_gate_bist #(.CHANNELS(CH), .SETTLE_CYCLES(S), .STOP_ON_FAIL(k == 1)) dut (
      .clk(clk), .rst(rst), .start(start[k]), .mode(mode), .a(a[k]), .b(b[k]), .y(y[k]),
      .busy(busy[k]), .done(done[k]), .pass(pass[k]), .fail_vector(fv[k]), .fail_mask(fm[k]),
      .err_count(err[k]));
    for (genvar i = 0; i < CH; i++) begin : g_gate
      assign y[k][i] = (fault_en && fch == i) ? fval : tt[gm][{b[k][i], a[k][i]}];
    end
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  // reference: walk every vector, apply the package model and the selected function's truth table
  function automatic exp_t model(int k, int md);
    exp_t r;
    logic [CH-1:0] m;
    bit ai, bi, yi;
    r.inst = k; r.pass = 0; r.fv = 0; r.fm = 0; r.err = 0;
    if (md > 5) begin
      r.fm = '1;
      r.lat = 1;
      return r;
    end
    r.lat = NV * (S + 2);
    for (int v = 0; v < NV; v++) begin
      m = 0;
      for (int i = 0; i < CH; i++) begin
        ai = 1'((v >> (2*i)) & 1);
        bi = 1'((v >> (2*i + 1)) & 1);
        yi = (fault_en && fch == i) ? fval : tt[gm][{bi, ai}];
        m[i] = yi != tt[md][{bi, ai}];
      end
      if (m != 0) begin
        if (r.err == 0) begin
          r.fv = (2*CH)'(v);
          r.fm = m;
        end
        r.err++;
        if (k == 1) begin
          r.lat = (v + 1) * (S + 2);
          break;
        end
      end
    end
    r.pass = r.err == 0;
    return r;
  endfunction
  for (genvar k = 0; k < 2; k++) begin : g_mon
    logic pd = 0;
    exp_t e;
    always @(negedge clk) begin
      if (!rst && done[k] && !pd) begin
        if (q.size() == 0 || q[0].inst != k) begin
          nvec++;
          nbad++;
          $display("FAIL unexpected_done inst %0d: got done=1 expected none", k);
        end else begin
          e = q.pop_front();
          chk("latency", cyc - acc_cyc, e.lat);
          chk("pass", pass[k], e.pass);
          chk("fail_vector", fv[k], e.fv);
          chk("fail_mask", fm[k], e.fm);
          chk("err_count", err[k], e.err);
          chk("busy_at_done", busy[k], 0);
          chk("ab_at_done", {a[k], b[k]}, 0);
        end
      end
      pd = done[k];
    end
  end
  task automatic wait_empty(int k, bit pokes);
    int t;
    for (t = 0; t < 3000 && q.size() != 0; t++) begin
      @(negedge clk);
      start[k] = pokes && busy[k] && $urandom_range(0, 19) == 0;
    end
    start[k] = 0;
    if (q.size() != 0) begin
      nvec++;
      nbad++;
      $display("FAIL timeout inst %0d: got no done expected done", k);
      q.delete();
    end
  endtask
  task automatic launch(int k, int md);
    @(negedge clk);
    mode = 3'(md);
    start[k] = 1;
    @(negedge clk);
    start[k] = 0;
    acc_cyc = cyc;
    mode = 3'($urandom_range(0, 7));
    q.push_back(model(k, md));
  endtask
  task automatic run(int k, int md, int g, bit fe, int fc, bit fvl, bit pokes);
    gm = g; fault_en = fe; fch = fc; fval = fvl;
    launch(k, md);
    wait_empty(k, pokes);
  endtask
  initial begin
    start[0] = 0; start[1] = 0; mode = 0;
    rst = 0;
    #1 rst = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_outputs", {a[k], b[k], busy[k], done[k], pass[k], fm[k]}, 0);
      chk("reset_counts", {fv[k], err[k]}, 0);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    run(0, 0, 0, 0, 0, 0, 0);
    run(0, 0, 0, 1, 2, 0, 1);
    run(0, 4, 0, 0, 0, 0, 0);
    run(1, 0, 0, 1, 2, 0, 1);
    run(0, 7, 0, 0, 0, 0, 0);
    run(1, 6, 0, 0, 0, 0, 0);
    gm = 0; fault_en = 0;
    launch(0, 0);
    for (int t = 0; t < 2000 && !(a[0] == 0 && b[0] == 4'h8); t++) @(negedge clk);
    #1 rst = 1;
    #1;
    chk("abort_ab", {a[0], b[0]}, 0);
    chk("abort_flags", {busy[0], done[0], pass[0], fm[0]}, 0);
    chk("abort_counts", {fv[0], err[0]}, 0);
    q.delete();
    #1 rst = 0;
    run(0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 10; n++)
      run($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
          $urandom_range(0, CH - 1), 1'($urandom_range(0, 1)), 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
